// File: rtl/gpu_pkg.sv
// Shared GPU core types used by the warp arbiter.
package gpu_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_RUN  = 1'b1
   } warp_arb_state_t;

endpackage

// File: rtl/warp_arbiter_if.sv
// Warp arbiter handshake bundle: per-warp status in, grant/select out.
interface warp_arbiter_if #(
   parameter int NUM_WARPS = 2
) ();
   localparam int WARP_BITS = $clog2(NUM_WARPS);

   logic [NUM_WARPS-1:0] warp_reset;
   logic [NUM_WARPS-1:0] warp_start;
   logic [NUM_WARPS-1:0] warp_done;
   logic [NUM_WARPS-1:0] mem_pending;
   logic                 boundary;
   logic                 boundary_mem;
   logic [WARP_BITS-1:0] warp_select;
   logic                 grant_valid;
   logic                 switch_pulse;
   logic                 all_done;

   // core side: reports warp status, consumes the grant
   modport master (
      output warp_reset, warp_start, warp_done, mem_pending, boundary, boundary_mem,
      input  warp_select, grant_valid, switch_pulse, all_done
   );

   // arbiter side
   modport slave (
      input  warp_reset, warp_start, warp_done, mem_pending, boundary, boundary_mem,
      output warp_select, grant_valid, switch_pulse, all_done
   );
endinterface

// File: rtl/warp_arbiter_rr_next_warp.sv
// Combinational round-robin picker: scans cur_idx+1, cur_idx+2, ... wrapping,
// with cur_idx itself tried last unless exclude_cur is set.
module rr_next_warp #(
   parameter  int NUM_WARPS = 2,
   localparam int WARP_BITS = $clog2(NUM_WARPS)
) (
   input  logic [NUM_WARPS-1:0] eligible,
   input  logic [WARP_BITS-1:0] cur_idx,
   input  logic                 exclude_cur,
   output logic                 found,
   output logic [WARP_BITS-1:0] idx
);
   localparam int SW = WARP_BITS + 1;

   logic [WARP_BITS-1:0] cand_idx [NUM_WARPS];
   logic [NUM_WARPS-1:0] cand_ok;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WARPS; gi++) begin : g_cand
         logic [SW-1:0] sum;
         assign sum = {1'b0, cur_idx} + SW'(gi + 1);
         assign cand_idx[gi] = (sum >= SW'(NUM_WARPS)) ? WARP_BITS'(sum - SW'(NUM_WARPS))
                                                       : sum[WARP_BITS-1:0];
         // the last slot in the scan is the current warp itself
         if (gi == NUM_WARPS - 1) begin : g_self
            assign cand_ok[gi] = eligible[cand_idx[gi]] & ~exclude_cur;
         end else begin : g_other
            assign cand_ok[gi] = eligible[cand_idx[gi]];
         end
      end
   endgenerate

   always_comb begin
      found = 1'b0;
      idx   = cur_idx;
      for (int i = NUM_WARPS - 1; i >= 0; i--) begin
         if (cand_ok[i]) begin
            found = 1'b1;
            idx   = cand_idx[i];
         end
      end
   end
endmodule

// File: rtl/warp_arbiter.sv
// Round-robin owner selection for the shared warp-muxed pipeline; rotates on
// memory parking, completion/reset of the owner, or quantum expiry.
module warp_arbiter
   import gpu_pkg::*;
#(
   parameter int NUM_WARPS = 2,
   parameter int QUANTUM   = 4
) (
   input logic           clk,
   input logic           reset,
   warp_arbiter_if.slave bus
);
   localparam int WARP_BITS = $clog2(NUM_WARPS);
   localparam int QCW       = $clog2(QUANTUM + 1);

   localparam logic [0:0]     ST_IDLE = ARB_IDLE;
   localparam logic [0:0]     ST_RUN  = ARB_RUN;
   localparam logic [QCW-1:0] Q_LAST  = QCW'(QUANTUM - 1);

   logic [0:0]           state_reg, state_next;
   logic [WARP_BITS-1:0] sel_reg, sel_next;
   logic                 valid_reg, valid_next;
   logic                 pulse_reg, pulse_next;
   logic                 all_done_reg, all_done_next;
   logic [QCW-1:0]       qcount_reg, qcount_next;
   logic                 granted_once_reg, granted_once_next;
   logic [NUM_WARPS-1:0] active_reg, active_next;
   logic [NUM_WARPS-1:0] parked_reg, parked_next;
   logic [NUM_WARPS-1:0] started_reg, started_next;
   logic [NUM_WARPS-1:0] done_seen_reg, done_seen_next;

   logic [NUM_WARPS-1:0] eligible;
   logic                 in_run, cur_stop, mem_yield, q_expire, run_mem_yield;
   logic [WARP_BITS-1:0] pick_cur, pick_idx;
   logic                 pick_excl, pick_found;

   assign eligible      = active_reg & ~parked_reg & ~bus.warp_done & ~bus.warp_reset;
   assign in_run        = (state_reg == ST_RUN);
   assign cur_stop      = bus.warp_done[sel_reg] | bus.warp_reset[sel_reg];
   assign mem_yield     = bus.boundary & bus.boundary_mem;
   assign q_expire      = bus.boundary & ~bus.boundary_mem & (qcount_reg == Q_LAST);
   assign run_mem_yield = in_run & mem_yield;

   // Before any grant there is no previous owner, so the scan starts at warp 0.
   always_comb begin
      pick_cur = sel_reg;
      if (!in_run && !granted_once_reg) begin
         pick_cur = WARP_BITS'(NUM_WARPS - 1);
      end
      // only a plain quantum expiry may fall back to the current owner
      pick_excl = in_run & ~(q_expire & ~cur_stop);
   end

   rr_next_warp #(.NUM_WARPS(NUM_WARPS)) u_pick (
      .eligible    (eligible),
      .cur_idx     (pick_cur),
      .exclude_cur (pick_excl),
      .found       (pick_found),
      .idx         (pick_idx)
   );

   always_comb begin
      state_next        = state_reg;
      sel_next          = sel_reg;
      valid_next        = valid_reg;
      pulse_next        = 1'b0;
      qcount_next       = qcount_reg;
      granted_once_next = granted_once_reg;
      if (!in_run) begin
         if (pick_found) begin
            state_next        = ST_RUN;
            valid_next        = 1'b1;
            sel_next          = pick_idx;
            pulse_next        = granted_once_reg & (pick_idx != sel_reg);
            granted_once_next = 1'b1;
            qcount_next       = '0;
         end
      end else if (cur_stop || mem_yield || q_expire) begin
         qcount_next = '0;
         if (!pick_found) begin
            state_next = ST_IDLE;
            valid_next = 1'b0;
         end else if (pick_idx != sel_reg) begin
            sel_next   = pick_idx;
            pulse_next = 1'b1;
         end
      end else if (bus.boundary) begin
         qcount_next = qcount_reg + QCW'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
         logic start_ok, park_set;
         assign start_ok = bus.warp_start[gi] & ~active_reg[gi] & ~bus.warp_reset[gi];
         assign park_set = run_mem_yield & (sel_reg == WARP_BITS'(gi));

         assign active_next[gi] = bus.warp_reset[gi] ? 1'b0 :
                                  start_ok           ? 1'b1 :
                                  bus.warp_done[gi]  ? 1'b0 : active_reg[gi];
         // parked drops on the first observed cycle with no LSU request in flight
         assign parked_next[gi] = bus.warp_reset[gi] ? 1'b0 :
                                  park_set           ? 1'b1 :
                                  (parked_reg[gi] & ~bus.mem_pending[gi]) ? 1'b0 : parked_reg[gi];
         assign started_next[gi]   = started_reg[gi] | start_ok;
         assign done_seen_next[gi] = bus.warp_reset[gi] ? 1'b0 :
                                     start_ok           ? 1'b0 :
                                     bus.warp_done[gi]  ? 1'b1 : done_seen_reg[gi];
      end
   endgenerate

   assign all_done_next = (|started_next) & (&(~started_next | done_seen_next));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_IDLE;
         sel_reg          <= '0;
         valid_reg        <= 1'b0;
         pulse_reg        <= 1'b0;
         all_done_reg     <= 1'b0;
         qcount_reg       <= '0;
         granted_once_reg <= 1'b0;
         active_reg       <= '0;
         parked_reg       <= '0;
         started_reg      <= '0;
         done_seen_reg    <= '0;
      end else begin
         state_reg        <= state_next;
         sel_reg          <= sel_next;
         valid_reg        <= valid_next;
         pulse_reg        <= pulse_next;
         all_done_reg     <= all_done_next;
         qcount_reg       <= qcount_next;
         granted_once_reg <= granted_once_next;
         active_reg       <= active_next;
         parked_reg       <= parked_next;
         started_reg      <= started_next;
         done_seen_reg    <= done_seen_next;
      end
   end

   assign bus.warp_select  = sel_reg;
   assign bus.grant_valid  = valid_reg;
   assign bus.switch_pulse = pulse_reg;
   assign bus.all_done     = all_done_reg;
endmodule
